// File: rtl/polar_pkg.sv
// ---------------------------------------------------------------------------
// polar_pkg
//   Shared definitions for the SC decoder core scheduler.
//   - code geometry (N, LAYERS) and the fixed datapath widths the
//     sequencer is built around
//   - FSM state encoding for llr_layer_sequencer
//   - PE operation encodings (f / g)
//   - layer_base(): base address of layer l in the LLR memory. The memory
//     is packed with layer LAYERS at address 0 (channel LLRs) and each
//     lower layer l stored at 2^ADDR_W - 2^(l+1), so layer 0 lands at the
//     very top (2046 for ADDR_W=11).
// ---------------------------------------------------------------------------
package polar_pkg;

    localparam int ID_W    = 10;          // log2(N)
    localparam int ADDR_W  = 11;          // LLR memory address width
    localparam int LAYER_W = 4;           // layer register width
    localparam int N       = 1 << ID_W;   // code length
    localparam int LAYERS  = ID_W;        // layers 0 .. LAYERS-1 are computed

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_BIT,
        S_DONE
    } seq_state_t;

    localparam logic OP_F = 1'b0;
    localparam logic OP_G = 1'b1;

    // Base address of layer l, wrapped to ADDR_W bits. layer_base(LAYERS)
    // wraps to 0, which is where the channel LLRs live.
    function automatic logic [ADDR_W-1:0] layer_base(input logic [LAYER_W-1:0] l);
        logic [ADDR_W:0] full;
        logic [ADDR_W:0] span;
        full = {1'b1, {ADDR_W{1'b0}}};
        span = (ADDR_W+1)'(1) << ({1'b0, l} + 5'd1);
        return ADDR_W'(full - span);
    endfunction

endpackage

// File: rtl/llr_layer_addr_gen.sv
// ---------------------------------------------------------------------------
// llr_layer_addr_gen
//   Per-layer request bookkeeping for the layer sequencer. Holds the current
//   layer l, its write base wb, the request counter k and the PE op, and
//   derives from them the read/write base of the current request, the number
//   of active PE lanes and whether this is the last request of the layer.
//
//   On an accepted request that closes layer l > 0 it steps to layer l-1:
//   the next write base is wb + 2^l and the op becomes f. Closing layer 0
//   leaves the registers untouched; the FSM moves on by itself.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   load          capture load_layer / load_wb / load_op, clear k
//   load_layer    starting layer
//   load_wb       write base of the starting layer
//   load_op       op of the starting layer (f or g)
//   accept        current request accepted by the PE array
//   layer         current layer
//   op            current op
//   rd_addr       read base of the current request (layer l+1 region)
//   wr_addr       write base of the current request (layer l region)
//   lane_cnt      active lanes, min(2^PE_LOG, 2^l)
//   last_req      current request is the last one of this layer
// ---------------------------------------------------------------------------
module llr_layer_addr_gen
    import polar_pkg::*;
#(
    parameter int ADDR_WIDTH      = 11,
    parameter int LAYER_OUT_WIDTH = 4,
    parameter int PE_LOG          = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [LAYER_OUT_WIDTH-1:0] load_layer,
    input  logic [ADDR_WIDTH-1:0]      load_wb,
    input  logic                       load_op,
    input  logic                       accept,
    output logic [LAYER_OUT_WIDTH-1:0] layer,
    output logic                       op,
    output logic [ADDR_WIDTH-1:0]      rd_addr,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic [PE_LOG:0]            lane_cnt,
    output logic                       last_req
);

    localparam int                       LANE_W   = PE_LOG + 1;
    localparam logic [LAYER_OUT_WIDTH-1:0] PE_LOG_L = LAYER_OUT_WIDTH'(PE_LOG);

    logic [ADDR_WIDTH-1:0] wb;
    logic [ADDR_WIDTH-1:0] k;
    logic [ADDR_WIDTH-1:0] reqs_m1;     // R(l) - 1
    logic [ADDR_WIDTH-1:0] rd_span;     // 2^(l+1): size of layer l+1 region
    logic [LAYER_OUT_WIDTH-1:0] layer_p1;

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        reqs_m1  = '0;
        layer_p1 = layer + LAYER_OUT_WIDTH'(1);
        rd_span  = ADDR_WIDTH'(1) << layer_p1;
        lane_cnt = LANE_W'(1) << layer;

        // Layers wider than the PE array need 2^l / P requests; narrower
        // layers fit in one request with only 2^l lanes busy.
        if (layer > PE_LOG_L) begin
            reqs_m1 = (ADDR_WIDTH'(1) << (layer - PE_LOG_L)) - ADDR_WIDTH'(1);
        end
        if (layer >= PE_LOG_L) begin
            lane_cnt = LANE_W'(1) << PE_LOG;
        end

        // Each request writes P LLRs of layer l and reads 2P of layer l+1.
        wr_addr  = wb + (k << PE_LOG);
        rd_addr  = wb - rd_span + (k << (PE_LOG + 1));
        last_req = (k == reqs_m1);
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer <= '0;
            wb    <= '0;
            k     <= '0;
            op    <= OP_F;
        end else if (load) begin
            layer <= load_layer;
            wb    <= load_wb;
            k     <= '0;
            op    <= load_op;
        end else if (accept) begin
            if (!last_req) begin
                k <= k + ADDR_WIDTH'(1);
            end else if (layer != '0) begin
                layer <= layer - LAYER_OUT_WIDTH'(1);
                wb    <= wb + (ADDR_WIDTH'(1) << layer);
                k     <= '0;
                op    <= OP_F;
            end
        end
    end

endmodule

// File: rtl/llr_layer_sequencer.sv
// ---------------------------------------------------------------------------
// llr_layer_sequencer
//   Top-level scheduler of the SC decoder core. Owns the decoded-bit index,
//   fetches the start layer / first write base for that bit from the
//   external start_layer_cal, walks the layers from there down to 0 issuing
//   f/g requests to the PE array, then presents the layer-0 LLR to the
//   decision/partial-sum unit and waits for it before the next bit.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   dec_start              pulse, starts a codeword decode (IDLE only)
//   id_counter_value       current bit index, to start_layer_cal
//   start_layer_num        start layer for the current bit (low bits used)
//   start_layer_init_addr  write base of the start layer
//   pe_req_valid/ready     PE request handshake
//   pe_op                  0 = f, 1 = g
//   pe_layer               layer being written
//   pe_rd_addr/pe_wr_addr  read base (layer l+1) / write base (layer l)
//   pe_lane_cnt            active lanes of this request
//   bit_llr_valid          layer-0 LLR of the current bit is ready
//   bit_done               pulse, current bit decided, partial sums updated
//   busy                   decoder not idle
//   dec_done               pulse after the last bit of the codeword
// ---------------------------------------------------------------------------
module llr_layer_sequencer
    import polar_pkg::*;
#(
    parameter int ID_COUNTER_WIDTH = 10,
    parameter int ADDR_WIDTH       = 11,
    parameter int LAYER_OUT_WIDTH  = 4,
    parameter int PE_LOG           = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dec_start,
    output logic [ID_COUNTER_WIDTH-1:0] id_counter_value,
    input  logic [ID_COUNTER_WIDTH:0]   start_layer_num,
    input  logic [ADDR_WIDTH-1:0]       start_layer_init_addr,
    output logic                        pe_req_valid,
    input  logic                        pe_req_ready,
    output logic                        pe_op,
    output logic [LAYER_OUT_WIDTH-1:0]  pe_layer,
    output logic [ADDR_WIDTH-1:0]       pe_rd_addr,
    output logic [ADDR_WIDTH-1:0]       pe_wr_addr,
    output logic [PE_LOG:0]             pe_lane_cnt,
    output logic                        bit_llr_valid,
    input  logic                        bit_done,
    output logic                        busy,
    output logic                        dec_done
);

    seq_state_t state, state_nxt;

    logic [ID_COUNTER_WIDTH-1:0] id;
    logic                        first_bit;
    logic                        last_bit;
    logic                        req_accept;

    logic [LAYER_OUT_WIDTH-1:0]  load_layer;
    logic [ADDR_WIDTH-1:0]       load_wb;
    logic                        load_op;

    logic [LAYER_OUT_WIDTH-1:0]  gen_layer;
    logic                        gen_op;
    logic [ADDR_WIDTH-1:0]       gen_rd_addr;
    logic [ADDR_WIDTH-1:0]       gen_wr_addr;
    logic [PE_LOG:0]             gen_lane_cnt;
    logic                        gen_last_req;

    // Only the low bits carry a layer number; the rest is the wider encoding
    // start_layer_cal happens to produce.
    logic unused_start_layer_bits;
    assign unused_start_layer_bits = ^start_layer_num[ID_COUNTER_WIDTH:LAYER_OUT_WIDTH];

    assign first_bit  = (id == '0);
    assign last_bit   = (id == {ID_COUNTER_WIDTH{1'b1}});
    assign req_accept = pe_req_valid && pe_req_ready;

    // Bit 0 has no decided bits behind it: the whole tree is computed with f
    // from the channel LLRs, starting at the top layer whatever
    // start_layer_cal reports as base.
    assign load_layer = start_layer_num[LAYER_OUT_WIDTH-1:0];
    assign load_wb    = first_bit ? ADDR_WIDTH'(layer_base(LAYER_W'(LAYERS - 1)))
                                  : start_layer_init_addr;
    assign load_op    = first_bit ? OP_F : OP_G;

    llr_layer_addr_gen #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .LAYER_OUT_WIDTH (LAYER_OUT_WIDTH),
        .PE_LOG          (PE_LOG)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (state == S_LOAD),
        .load_layer (load_layer),
        .load_wb    (load_wb),
        .load_op    (load_op),
        .accept     (req_accept),
        .layer      (gen_layer),
        .op         (gen_op),
        .rd_addr    (gen_rd_addr),
        .wr_addr    (gen_wr_addr),
        .lane_cnt   (gen_lane_cnt),
        .last_req   (gen_last_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id <= '0;
        end else begin
            unique case (state)
                S_IDLE:     if (dec_start) id <= '0;
                S_WAIT_BIT: if (bit_done && !last_bit) id <= id + ID_COUNTER_WIDTH'(1);
                S_DONE:     id <= '0;
                default:    ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (dec_start) state_nxt = S_LOAD;
            S_LOAD:     state_nxt = S_ISSUE;
            S_ISSUE:    if (req_accept && gen_last_req && gen_layer == '0)
                            state_nxt = S_WAIT_BIT;
            S_WAIT_BIT: if (bit_done) state_nxt = last_bit ? S_DONE : S_LOAD;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Request fields are forced to zero outside ISSUE so the PE interface is
    // quiet whenever no request is offered (including during reset).
    always_comb begin
        pe_req_valid  = (state == S_ISSUE);
        pe_op         = OP_F;
        pe_layer      = '0;
        pe_rd_addr    = '0;
        pe_wr_addr    = '0;
        pe_lane_cnt   = '0;
        if (pe_req_valid) begin
            pe_op       = gen_op;
            pe_layer    = gen_layer;
            pe_rd_addr  = gen_rd_addr;
            pe_wr_addr  = gen_wr_addr;
            pe_lane_cnt = gen_lane_cnt;
        end
        bit_llr_valid    = (state == S_WAIT_BIT);
        busy             = (state != S_IDLE);
        dec_done         = (state == S_DONE);
        id_counter_value = id;
    end

endmodule

// File: tb/tb_llr_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_llr_layer_sequencer
//   Bench for llr_layer_sequencer. A behavioural start_layer_cal drives the
//   start layer / base from the bit index. For every bit the expected PE
//   request list is pushed into a queue from closed-form layer addresses and
//   popped as the DUT's requests are accepted.
// ---------------------------------------------------------------------------
module tb_llr_layer_sequencer;

    localparam int IDW = 10;
    localparam int AW  = 11;
    localparam int LW  = 4;
    localparam int PL  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            dec_start;
    logic [IDW-1:0]  id_counter_value;
    logic [IDW:0]    start_layer_num;
    logic [AW-1:0]   start_layer_init_addr;
    logic            pe_req_valid;
    logic            pe_req_ready;
    logic            pe_op;
    logic [LW-1:0]   pe_layer;
    logic [AW-1:0]   pe_rd_addr;
    logic [AW-1:0]   pe_wr_addr;
    logic [PL:0]     pe_lane_cnt;
    logic            bit_llr_valid;
    logic            bit_done;
    logic            busy;
    logic            dec_done;

    typedef struct {
        bit op;
        int layer;
        int rd;
        int wr;
        int lanes;
    } req_t;

    req_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   done_pulses = 0;

    always #5 clk = ~clk;

    llr_layer_sequencer dut (
        .clk                   (clk),
        .rst                   (rst),
        .dec_start             (dec_start),
        .id_counter_value      (id_counter_value),
        .start_layer_num       (start_layer_num),
        .start_layer_init_addr (start_layer_init_addr),
        .pe_req_valid          (pe_req_valid),
        .pe_req_ready          (pe_req_ready),
        .pe_op                 (pe_op),
        .pe_layer              (pe_layer),
        .pe_rd_addr            (pe_rd_addr),
        .pe_wr_addr            (pe_wr_addr),
        .pe_lane_cnt           (pe_lane_cnt),
        .bit_llr_valid         (bit_llr_valid),
        .bit_done              (bit_done),
        .busy                  (busy),
        .dec_done              (dec_done)
    );

    function automatic int ctz(input int v);
        for (int i = 0; i < IDW; i++) if (v[i]) return i;
        return IDW - 1;
    endfunction

    // Layer l region starts at 2048 - 2^(l+1); layer 10 wraps to 0.
    function automatic int base(input int l);
        return ((1 << AW) - (1 << (l + 1))) & ((1 << AW) - 1);
    endfunction

    // Behavioural start_layer_cal. For bit 0 the base is deliberately junk:
    // the sequencer must use the top-layer base on its own.
    always_comb begin
        start_layer_num       = '0;
        start_layer_init_addr = '0;
        if (id_counter_value == '0) begin
            start_layer_num       = (IDW+1)'(9);
            start_layer_init_addr = AW'(12'h5A5);
        end else begin
            start_layer_num       = (IDW+1)'(ctz(int'(id_counter_value)));
            start_layer_init_addr = AW'(base(ctz(int'(id_counter_value))));
        end
    end

    always @(posedge clk) if (dec_done === 1'b1) done_pulses++;

    task automatic push_bit(input int id);
        int   l0;
        int   nreq;
        req_t e;
        l0 = (id == 0) ? 9 : ctz(id);
        for (int l = l0; l >= 0; l--) begin
            nreq = (l > PL) ? (1 << (l - PL)) : 1;
            for (int k = 0; k < nreq; k++) begin
                e.op    = (l == l0) && (id != 0);
                e.layer = l;
                e.wr    = (base(l) + 16 * k) & 2047;
                e.rd    = (base(l + 1) + 32 * k) & 2047;
                e.lanes = (l >= PL) ? 16 : (1 << l);
                exp_q.push_back(e);
            end
        end
    endtask

    // Service one bit from its LOAD cycle until WAIT_BIT. mode 0: ready high
    // except a 5-cycle stall once stall_at requests were accepted; mode 1:
    // random ready. poke drives bit_done and dec_start during ISSUE.
    task automatic service_bit(input int id, input int mode, input int stall_at, input bit poke);
        int   cyc = 0;
        int   accepts = 0;
        int   stall_left = 5;
        bit   held = 0;
        req_t e;
        logic [AW+AW+LW+PL+1:0] saved;
        push_bit(id);
        while (exp_q.size() > 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            bit_done  = poke && (cyc == 2);
            dec_start = poke && (cyc == 3);
            if (mode == 1) begin
                pe_req_ready = 1'($urandom_range(0, 1));
            end else if (stall_at >= 0 && accepts == stall_at && stall_left > 0) begin
                pe_req_ready = 1'b0;
                stall_left--;
            end else begin
                pe_req_ready = 1'b1;
            end
            if (cyc == 1) begin
                vectors++;
                if (pe_req_valid !== 1'b0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL load_cycle bit=%0d: valid=%b busy=%b, want valid=0 busy=1",
                             id, pe_req_valid, busy);
                end
            end
            if (cyc == 2) begin
                vectors++;
                if (pe_req_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL first_req_latency bit=%0d: valid=%b, want 1", id, pe_req_valid);
                end
            end
            if (held) begin
                vectors++;
                if (pe_req_valid !== 1'b1 ||
                    {pe_op, pe_layer, pe_rd_addr, pe_wr_addr, pe_lane_cnt} !== saved) begin
                    miscompares++;
                    $display("FAIL stall_hold bit=%0d: valid=%b fields=%h, want valid=1 fields=%h",
                             id, pe_req_valid,
                             {pe_op, pe_layer, pe_rd_addr, pe_wr_addr, pe_lane_cnt}, saved);
                end
            end
            held = 1'b0;
            if (pe_req_valid === 1'b1 && pe_req_ready) begin
                e = exp_q.pop_front();
                vectors++;
                if (pe_op !== e.op || pe_layer !== LW'(e.layer) || pe_rd_addr !== AW'(e.rd) ||
                    pe_wr_addr !== AW'(e.wr) || pe_lane_cnt !== (PL+1)'(e.lanes)) begin
                    miscompares++;
                    $display("FAIL req bit=%0d n=%0d: op=%0d layer=%0d rd=%0d wr=%0d lanes=%0d, want op=%0d layer=%0d rd=%0d wr=%0d lanes=%0d",
                             id, accepts, pe_op, pe_layer, pe_rd_addr, pe_wr_addr, pe_lane_cnt,
                             e.op, e.layer, e.rd, e.wr, e.lanes);
                end
                accepts++;
            end else if (pe_req_valid === 1'b1) begin
                held  = 1'b1;
                saved = {pe_op, pe_layer, pe_rd_addr, pe_wr_addr, pe_lane_cnt};
            end
        end
        bit_done  = 1'b0;
        dec_start = 1'b0;
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL req_timeout bit=%0d: %0d requests missing, want 0", id, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        vectors++;
        if (pe_req_valid !== 1'b0 || bit_llr_valid !== 1'b1 || busy !== 1'b1 ||
            id_counter_value !== IDW'(id)) begin
            miscompares++;
            $display("FAIL wait_bit bit=%0d: valid=%b llr_valid=%b busy=%b id=%0d, want 0 1 1 %0d",
                     id, pe_req_valid, bit_llr_valid, busy, id_counter_value, id);
        end
    endtask

    task automatic finish_bit(input int delay);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            vectors++;
            if (bit_llr_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL llr_valid_hold: got %b, want 1", bit_llr_valid);
            end
        end
        bit_done = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        vectors++;
        if ({id_counter_value, pe_req_valid, pe_op, pe_layer, pe_rd_addr, pe_wr_addr,
             pe_lane_cnt, bit_llr_valid, busy, dec_done} !== '0) begin
            miscompares++;
            $display("FAIL %s: id=%0d valid=%b op=%b layer=%0d rd=%0d wr=%0d lanes=%0d llr=%b busy=%b done=%b, want all 0",
                     tag, id_counter_value, pe_req_valid, pe_op, pe_layer, pe_rd_addr,
                     pe_wr_addr, pe_lane_cnt, bit_llr_valid, busy, dec_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dec_start = 1'b0;
        pe_req_ready = 1'b0;
        bit_done = 1'b0;
        #1;
        check_quiet("reset_state");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_quiet("after_reset");
    endtask

    task automatic test_idle_ignores();
        bit_done = 1'b1;
        @(negedge clk);
        bit_done = 1'b0;
        @(negedge clk);
        check_quiet("idle_bit_done");
    endtask

    task automatic run_decode(input int mode);
        done_pulses = 0;
        @(negedge clk);
        dec_start = 1'b1;
        for (int id = 0; id < 1024; id++) begin
            service_bit(id, mode, (mode == 0 && id == 0) ? 40 : -1, (mode == 1 && id == 512));
            finish_bit((mode == 1) ? int'($urandom_range(0, 3)) : 0);
        end
        @(negedge clk);
        bit_done = 1'b0;
        vectors++;
        if (dec_done !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL done_pulse: dec_done=%b busy=%b, want 1 1", dec_done, busy);
        end
        @(negedge clk);
        check_quiet("back_to_idle");
        vectors++;
        if (done_pulses !== 1) begin
            miscompares++;
            $display("FAIL done_count: got %0d pulses, want 1", done_pulses);
        end
    endtask

    task automatic test_decode_directed();
        run_decode(0);
    endtask

    task automatic test_decode_random();
        run_decode(1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        dec_start = 1'b1;
        for (int id = 0; id < 37; id++) begin
            service_bit(id, 0, -1, 1'b0);
            finish_bit(0);
        end
        @(negedge clk);
        bit_done = 1'b0;
        pe_req_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (pe_req_valid !== 1'b1 || pe_op !== 1'b1 || pe_layer !== '0 ||
            id_counter_value !== IDW'(37)) begin
            miscompares++;
            $display("FAIL bit37_issue: valid=%b op=%b layer=%0d id=%0d, want 1 1 0 37",
                     pe_req_valid, pe_op, pe_layer, id_counter_value);
        end
        #2 rst = 1'b1;
        #1 check_quiet("async_reset");
        @(negedge clk);
        check_quiet("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("reset_released");
        dec_start = 1'b1;
        service_bit(0, 0, -1, 1'b0);
        finish_bit(0);
        service_bit(1, 0, -1, 1'b0);
        finish_bit(0);
        @(negedge clk);
        bit_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_ignores();
        test_decode_directed();
        test_decode_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/llr_layer_sequencer.md
Name: llr_layer_sequencer

Overview:
- Top-level scheduler of the SC decoder core.
- Owns the decoded-bit index counter, which drives start_layer_cal.
- Takes back the start layer and first write address, then walks layers from the start layer down to 0, issuing f/g requests to the PE array.
- Hands the final LLR to the decision/partial-sum unit and advances the bit index until all N bits are decoded.

Parameters:
- ID_COUNTER_WIDTH, 10, log2 of code length N (N=1024).
- ADDR_WIDTH, 11, LLR memory address width (channel 0..1023, layer l base 2^11-2^(l+1)).
- LAYER_OUT_WIDTH, 4, width of the internal layer register and the pe_layer port.
- PE_LOG, 4, log2 of the PE count P (P=16 lanes per request).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- dec_start  in  1  one-cycle pulse; starts a codeword decode; ignored unless IDLE.
- id_counter_value  out  ID_COUNTER_WIDTH  current bit index, to start_layer_cal.
- start_layer_num  in  ID_COUNTER_WIDTH+1  start layer from start_layer_cal; low LAYER_OUT_WIDTH bits used.
- start_layer_init_addr  in  ADDR_WIDTH  first-layer write base from start_layer_cal.
- pe_req_valid  out  1  PE request valid.
- pe_req_ready  in  1  PE accepts the request.
- pe_op  out  1  0=f, 1=g.
- pe_layer  out  LAYER_OUT_WIDTH  layer being written.
- pe_rd_addr  out  ADDR_WIDTH  read base of this request (layer l+1).
- pe_wr_addr  out  ADDR_WIDTH  write base of this request (layer l).
- pe_lane_cnt  out  PE_LOG+1  active lanes: min(P, 2^l).
- bit_llr_valid  out  1  level; layer-0 LLR for id_counter_value is ready at address 2046.
- bit_done  in  1  pulse from the decision/partial-sum unit; bit decided and partial sums updated.
- busy  out  1  high in any state except IDLE.
- dec_done  out  1  one-cycle pulse after the last bit completes.

Behaviour:
- Reset (async, rst=1): state IDLE; id_counter_value=0; all outputs 0.
- FSM states: IDLE, LOAD, ISSUE, WAIT_BIT, DONE.
- IDLE:
  - dec_start=1 -> LOAD; id_counter_value=0.
- LOAD (1 cycle):
  - Latch layer l=start_layer_num.
  - Write base wb = start_layer_init_addr, except id==0 where wb=1024.
  - Op = g if id!=0, f if id==0.
  - Request counter k=0.
  - -> ISSUE.
- ISSUE:
  - pe_req_valid=1 with pe_wr_addr=wb+k*P, pe_rd_addr=(wb-2^(l+1))+2k*P, pe_layer=l.
  - Requests per layer R(l)=max(1, 2^l>>PE_LOG).
  - All fields are held stable while valid&&!ready; no request is ever dropped.
  - On each accept, k++.
  - On the last accept of a layer:
    - If l>0: l--, wb+=2^l (old l), op=f, k=0, stay in ISSUE. The next request is valid in the following cycle; one bubble between layers is allowed.
    - If l==0: -> WAIT_BIT.
- WAIT_BIT:
  - bit_llr_valid=1 until bit_done.
  - On bit_done, if id==N-1 -> DONE; else id++ and -> LOAD.
  - bit_done outside WAIT_BIT is ignored.
- DONE: dec_done=1 for one cycle; id wraps to 0; -> IDLE.
- Latency: dec_start at cycle T -> LOAD at T+1 -> first pe_req_valid at T+2.
- Arithmetic: addresses are computed modulo 2^ADDR_WIDTH. The read base for l=9 is 0 (channel LLRs).
- Simultaneous dec_start while busy: ignored, no restart.
- Reset mid-operation: immediate return to IDLE. Any in-flight request is abandoned, with no completion signalled.

Decomposition:
- Shared package polar_pkg holds:
  - state enum seq_state_t;
  - N, LAYERS=10;
  - function layer_base(l) returning 2^ADDR_WIDTH-2^(l+1);
  - op encodings OP_F/OP_G.
- One natural sub-module: llr_layer_addr_gen, holding wb, k and l and producing rd/wr addresses and lane count.
- The FSM stays in llr_layer_sequencer.
- start_layer_cal is instantiated by the parent, not inside this block.

Test Plan:
- Bit 0, pe_req_ready=1 -> layer 9:
  - f, 32 requests, wr 1024..1520 step 16, rd 0..992 step 32.
  - Then layers 8..0 all f.
  - 67 requests total.
  - Last request: layer 0, wr 2046, rd 2044, lanes 1.
- Bit 1 (after bit_done) -> single request: g, layer 0, wr 2046, rd 2044, lanes 1; then bit_llr_valid=1.
- Bit 512 -> first request: g, layer 9, wr 1024, rd 0; 32 g requests, then f on layers 8..0; 67 requests.
- Backpressure: pe_req_ready low for 5 cycles mid layer 8 -> fields stable, no request skipped, request count unchanged.
- Full decode with random ready and bit_done delays:
  - dec_done pulses exactly once after the 1024th bit_done;
  - id returns to 0;
  - busy falls;
  - a dec_start during decode has no effect.
- Assert rst during ISSUE of bit 37 -> all outputs 0 asynchronously; after release, dec_start restarts at bit 0.
